// File: rtl/serial_adder_sched_if.sv
// rtl/serial_adder_sched_if.sv - request, result and half-adder pins of the serial adder sequencer
interface serial_adder_sched_if #(
  parameter int WIDTH = 8
);
  logic             i_req0_valid;
  logic             o_req0_ready;
  logic [WIDTH-1:0] i_req0_a;
  logic [WIDTH-1:0] i_req0_b;
  logic             i_req1_valid;
  logic             o_req1_ready;
  logic [WIDTH-1:0] i_req1_a;
  logic [WIDTH-1:0] i_req1_b;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [WIDTH-1:0] o_res_sum;
  logic             o_res_carry;
  logic             o_res_id;
  logic             o_ha_bit1;
  logic             o_ha_bit2;
  logic             i_ha_sum;
  logic             i_ha_carry;

  modport slave (
    input  i_req0_valid, i_req0_a, i_req0_b,
    input  i_req1_valid, i_req1_a, i_req1_b,
    input  i_res_ready, i_ha_sum, i_ha_carry,
    output o_req0_ready, o_req1_ready,
    output o_res_valid, o_res_sum, o_res_carry, o_res_id,
    output o_ha_bit1, o_ha_bit2
  );

  modport master (
    output i_req0_valid, i_req0_a, i_req0_b,
    output i_req1_valid, i_req1_a, i_req1_b,
    output i_res_ready, i_ha_sum, i_ha_carry,
    input  o_req0_ready, o_req1_ready,
    input  o_res_valid, o_res_sum, o_res_carry, o_res_id,
    input  o_ha_bit1, o_ha_bit2
  );
endinterface

// File: rtl/serial_adder_sched.sv
// rtl/serial_adder_sched.sv - two-way round-robin sequencer for bit-serial adds on an external half adder
module serial_adder_sched #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_sched_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic             cin;
  logic             s1;
  logic             c1;
  logic             last_grant;
  logic             id_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             grant_any;
  logic             grant_id;
  logic             accept;

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant_any = bus.i_req0_valid | bus.i_req1_valid;
    if (bus.i_req0_valid && bus.i_req1_valid) grant_id = ~last_grant;
    else                                      grant_id = bus.i_req1_valid;
  end

  assign accept = (state == IDLE) && grant_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = PASS1;
      PASS1: state_nxt = PASS2;
      PASS2: state_nxt = (idx == LAST_IDX) ? DONE : PASS1;
      DONE:  if (bus.i_res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_req0_ready = 1'b0;
    bus.o_req1_ready = 1'b0;
    bus.o_res_valid  = 1'b0;
    bus.o_ha_bit1    = 1'b0;
    bus.o_ha_bit2    = 1'b0;
    case (state)
      IDLE: begin
        bus.o_req0_ready = bus.i_req0_valid & ~grant_id;
        bus.o_req1_ready = bus.i_req1_valid & grant_id;
      end
      PASS1: begin
        bus.o_ha_bit1 = a_reg[idx];
        bus.o_ha_bit2 = b_reg[idx];
      end
      PASS2: begin
        bus.o_ha_bit1 = s1;
        bus.o_ha_bit2 = cin;
      end
      DONE: bus.o_res_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_res_sum   = sum_reg;
  assign bus.o_res_carry = carry_reg;
  assign bus.o_res_id    = id_reg;

  // Full-adder per bit: pass 1 gives a^b and a&b, pass 2 folds in the running carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      cin        <= 1'b0;
      s1         <= 1'b0;
      c1         <= 1'b0;
      last_grant <= 1'b1;
      id_reg     <= 1'b0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_reg      <= grant_id ? bus.i_req1_a : bus.i_req0_a;
          b_reg      <= grant_id ? bus.i_req1_b : bus.i_req0_b;
          id_reg     <= grant_id;
          last_grant <= grant_id;
          idx        <= '0;
          cin        <= 1'b0;
        end
        PASS1: begin
          s1 <= bus.i_ha_sum;
          c1 <= bus.i_ha_carry;
        end
        PASS2: begin
          sum_reg[idx] <= bus.i_ha_sum;
          cin          <= c1 | bus.i_ha_carry;
          if (idx == LAST_IDX) carry_reg <= c1 | bus.i_ha_carry;
          else                 idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_sched.sv
// tb/tb_serial_adder_sched.sv - scoreboard bench for serial_adder_sched with a behavioural half adder
module tb_serial_adder_sched;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_sched_if #(.WIDTH(W)) bus ();

  // The half adder the sequencer time-shares.
  assign bus.i_ha_sum   = bus.o_ha_bit1 ^ bus.o_ha_bit2;
  assign bus.i_ha_carry = bus.o_ha_bit1 & bus.o_ha_bit2;

  serial_adder_sched #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic id_log[$];
  logic model_last = 1'b1;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;
  logic [W-1:0] prev_sum;
  logic prev_carry, prev_id;
  logic rand_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (p == 0) begin
      bus.i_req0_valid = v; bus.i_req0_a = a; bus.i_req0_b = b;
    end else begin
      bus.i_req1_valid = v; bus.i_req1_a = a; bus.i_req1_b = b;
    end
  endtask

  function automatic logic hs(input int p);
    if (p == 0) return bus.i_req0_valid & bus.o_req0_ready;
    return bus.i_req1_valid & bus.o_req1_ready;
  endfunction

  // Returns just after the edge that accepted requester p's pending request.
  task automatic wait_accept(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hs(p) && n < 2000);
    chk($sformatf("accept_timeout_p%0d", p), {31'd0, hs(p)}, 32'd1);
    @(posedge clk);
    #1;
    set_req(p, 1'b0, '0, '0);
  endtask

  task automatic send(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
    set_req(p, 1'b1, a, b);
    wait_accept(p);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || bus.o_res_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic driver(input int p, input int n_ops);
    for (int i = 0; i < n_ops; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(p, W'($urandom), W'($urandom));
    end
  endtask

  // Monitor: predicts grants, records expected results on acceptance, checks results on handshake.
  always @(negedge clk) begin
    logic r0, r1, v0, v1, exp_g;
    logic [W:0] tot;
    exp_t e;
    if (rst) begin
      q.delete();
      model_last = 1'b1;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      r0 = bus.o_req0_ready; r1 = bus.o_req1_ready;
      v0 = bus.i_req0_valid; v1 = bus.i_req1_valid;
      if (r0 | r1) begin
        chk("one_ready", {31'd0, r0 & r1}, 0);
        chk("ready_without_valid", {31'd0, (r0 & ~v0) | (r1 & ~v1)}, 0);
        chk("ha_pins_idle", {30'd0, bus.o_ha_bit1, bus.o_ha_bit2}, 0);
        exp_g = (v0 && v1) ? ~model_last : v1;
        chk("grant_id", {31'd0, r1}, {31'd0, exp_g});
        if (r1) tot = {1'b0, bus.i_req1_a} + {1'b0, bus.i_req1_b};
        else    tot = {1'b0, bus.i_req0_a} + {1'b0, bus.i_req0_b};
        e.sum = tot[W-1:0]; e.carry = tot[W]; e.id = r1;
        q.push_back(e);
        model_last = r1;
        accept_cyc = cyc;
      end
      if (bus.o_res_valid) begin
        chk("ha_pins_done", {30'd0, bus.o_ha_bit1, bus.o_ha_bit2}, 0);
        chk("ready_in_done", {30'd0, r0, r1}, 0);
        if (!prev_valid) chk("latency", cyc - accept_cyc, 2 * W + 1);
        else if (!prev_hs) begin
          chk("hold_sum", bus.o_res_sum, prev_sum);
          chk("hold_carry", bus.o_res_carry, prev_carry);
          chk("hold_id", bus.o_res_id, prev_id);
        end
        if (bus.i_res_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_result: got sum 0x%0h with no request outstanding", bus.o_res_sum);
          end else begin
            e = q.pop_front();
            chk("res_sum", bus.o_res_sum, e.sum);
            chk("res_carry", bus.o_res_carry, e.carry);
            chk("res_id", bus.o_res_id, e.id);
            id_log.push_back(bus.o_res_id);
          end
        end
      end
      if (prev_hs) begin
        chk("valid_drop", bus.o_res_valid, 0);
        chk("idle_after_hs", {31'd0, r0 | r1}, {31'd0, v0 | v1});
      end
      prev_valid = bus.o_res_valid;
      prev_hs    = bus.o_res_valid & bus.i_res_ready;
      prev_sum   = bus.o_res_sum;
      prev_carry = bus.o_res_carry;
      prev_id    = bus.o_res_id;
    end
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    bus.i_res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", bus.o_res_valid, 0);
    chk("rst_ha", {30'd0, bus.o_ha_bit1, bus.o_ha_bit2}, 0);
    chk("rst_readys", {30'd0, bus.o_req0_ready, bus.o_req1_ready}, 0);
    chk("rst_sum", bus.o_res_sum, 0);
    chk("rst_carry_id", {30'd0, bus.o_res_carry, bus.o_res_id}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(0, 8'h3C, 8'h05); wait_drain();
    send(1, 8'hFF, 8'h01); wait_drain();
    send(1, 8'hFF, 8'hFF); wait_drain();

    id_log.delete();
    fork
      begin send(0, 8'h11, 8'h22); send(0, 8'h80, 8'h80); end
      begin send(1, 8'h7F, 8'h01); send(1, 8'hC3, 8'h3C); end
    join
    wait_drain();
    chk("alt_count", id_log.size(), 4);
    if (id_log.size() == 4)
      chk("alt_ids", {28'd0, id_log[0], id_log[1], id_log[2], id_log[3]}, 32'b0101);

    bus.i_res_ready = 1'b0;
    send(0, 8'hA5, 8'h5A);
    n = 0;
    while (!bus.o_res_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_valid_seen", bus.o_res_valid, 1);
    set_req(1, 1'b1, 8'h12, 8'h34);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("bp_no_accept", q.size(), 1);
    bus.i_res_ready = 1'b1;
    wait_accept(1);
    wait_drain();

    set_req(0, 1'b1, 8'h37, 8'h29);
    wait_accept(0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_res_valid", bus.o_res_valid, 0);
    chk("abort_ha", {30'd0, bus.o_ha_bit1, bus.o_ha_bit2}, 0);
    chk("abort_sum", bus.o_res_sum, 0);
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 8'h01, 8'h01);
    set_req(1, 1'b1, 8'h01, 8'h01);
    rst = 1'b0;
    fork
      wait_accept(0);
      wait_accept(1);
    join
    wait_drain();

    fork
      begin
        fork
          driver(0, 250);
          driver(1, 250);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 bus.i_res_ready = ($urandom_range(0, 3) != 0);
        end
        bus.i_res_ready = 1'b1;
      end
    join
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder_sched.md
Name: serial_adder_sched

Overview:
- Sequencer and two-way arbiter for the shared 1-bit half-adder datapath.
- Accepts WIDTH-bit add requests from two requesters and performs the addition bit-serially, LSB first, on one external half adder.
- Each bit takes two half-adder passes:
  - pass 1: a + b
  - pass 2: partial sum + carry-in
- Returns the WIDTH-bit sum, carry-out and requester ID through a valid/ready result port.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- i_req0_valid  input  1  requester 0 has an operand pair
- o_req0_ready  output  1  requester 0 accepted this cycle when valid&ready
- i_req0_a  input  WIDTH  requester 0 operand A
- i_req0_b  input  WIDTH  requester 0 operand B
- i_req1_valid  input  1  requester 1 has an operand pair
- o_req1_ready  output  1  requester 1 accepted this cycle when valid&ready
- i_req1_a  input  WIDTH  requester 1 operand A
- i_req1_b  input  WIDTH  requester 1 operand B
- o_res_valid  output  1  result available
- i_res_ready  input  1  consumer takes result
- o_res_sum  output  WIDTH  a+b mod 2^WIDTH
- o_res_carry  output  1  carry-out of a+b
- o_res_id  output  1  requester that issued the result
- o_ha_bit1  output  1  drives half-adder i_bit1
- o_ha_bit2  output  1  drives half-adder i_bit2
- i_ha_sum  input  1  half-adder o_sum (combinational return)
- i_ha_carry  input  1  half-adder o_carry (combinational return)

Behaviour:
- States:
  - IDLE: no operation in flight; arbitrating.
  - PASS1: first half-adder pass for the current bit.
  - PASS2: second half-adder pass for the current bit.
  - DONE: result held for the consumer.
- Reset values:
  - State = IDLE, bit index = 0, cin = 0.
  - Result registers = 0, o_res_valid = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - o_ha_bit1 = 0, o_ha_bit2 = 0.
- Ready signals and arbitration:
  - o_reqN_ready is combinational.
  - It is 1 only in IDLE and only for the granted requester.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted (round-robin).
  - Neither valid: both readys are 0.
  - Ready never depends on the other port's ready.
- Acceptance (valid&ready in IDLE):
  - Latch a, b and the ID.
  - Set last_grant = ID, idx = 0, cin = 0.
  - Next state = PASS1.
- PASS1:
  - Drive o_ha_bit1 = a[idx], o_ha_bit2 = b[idx].
  - Register s1 ← i_ha_sum, c1 ← i_ha_carry.
  - Next state = PASS2.
- PASS2:
  - Drive o_ha_bit1 = s1, o_ha_bit2 = cin.
  - Register sum[idx] ← i_ha_sum and cin ← c1 | i_ha_carry.
  - If idx == WIDTH-1: carry ← c1 | i_ha_carry, next state = DONE.
  - Otherwise: idx++, next state = PASS1.
- o_ha_bit1/o_ha_bit2 are 0 in IDLE and DONE.
- Latency:
  - Acceptance edge at cycle k → o_res_valid = 1 from cycle k+1+2·WIDTH.
  - No operand reuse or early termination.
- DONE:
  - o_res_valid = 1.
  - o_res_sum, o_res_carry and o_res_id are stable until the handshake.
  - On i_res_ready: o_res_valid drops next cycle and state = IDLE.
  - A new request is accepted no earlier than the cycle after the result handshake; there is no overlap.
- Result outputs keep their last values after the handshake; they are valid only while o_res_valid = 1.
- Request ports are ignored outside IDLE; operand changes after acceptance have no effect.
- Reset mid-operation:
  - Everything returns to reset values immediately (asynchronous).
  - In-flight result is discarded and no o_res_valid is produced.
  - last_grant returns to 1.
- Arithmetic: the full-adder identity is built only from the two half-adder passes; the block contains no '+' on operand data.
- Wrap-around: carry is reported in o_res_carry; the sum wraps modulo 2^WIDTH.

Test Plan:
- WIDTH=8, requester 0 only, a=0x3C, b=0x05 → o_res_sum=0x41, carry=0, id=0; o_res_valid rises exactly 17 cycles after the acceptance edge.
- a=0xFF, b=0x01 on requester 1 → sum=0x00, carry=1, id=1; a=0xFF, b=0xFF → sum=0xFE, carry=1.
- Both requesters valid continuously, i_res_ready=1:
  - IDs alternate 0,1,0,1 across four results.
  - Only one ready is high per IDLE cycle; ha pins are 0 in IDLE/DONE.
- Backpressure: hold i_res_ready=0 for 10 cycles in DONE → sum/carry/id stable, both reqN_ready=0, no new acceptance; release → IDLE next cycle.
- Assert rst during PASS2 at idx=3, then deassert and issue a=0x01, b=0x01 on both requesters:
  - No result emitted for the aborted operation.
  - Requester 0 is granted first; sum=0x02, carry=0.
- Random 500 operand pairs on both ports against a reference model, with the existing half adder instantiated on the ha pins → all sums/carries/IDs match.
